// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative multiply/divide sequencer for the EX stage.
//
// Computes MULT, MULTU, DIV and DIVU one bit per cycle, holding the pipeline
// through stallreq_for_md while busy. The HI/LO pair is presented on hi_o/lo_o
// together with a one-cycle md_done pulse, which EX turns into the hi/lo write.
//
// Ports:
//   clk              pipeline clock, rising edge
//   rst              asynchronous, active-high reset
//   md_op            {inst_div, inst_divu, inst_mult, inst_multu}, one-hot or zero
//   md_src1          rs value (dividend / multiplicand)
//   md_src2          rt value (divisor / multiplier)
//   annul            flush: cancels the current or pending operation
//   stallreq_for_md  freeze IF..EX while an operation is starting or in flight
//   md_done          one-cycle pulse, hi_o/lo_o valid
//   hi_o             remainder (div) or upper product half (mult)
//   lo_o             quotient (div) or lower product half (mult)
module mdu_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] md_src1,
  input  logic [WIDTH-1:0] md_src2,
  input  logic             annul,
  output logic             stallreq_for_md,
  output logic             md_done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = 6;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e state_q, state_d;

  // Two's-complement negation helpers.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + (2*WIDTH)'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Operation decode (only meaningful in StIdle)
  // ---------------------------------------------------------------------------
  logic             op_div, op_divu, op_mult;
  logic             is_div_op, signed_op, start, div_by_zero;
  logic             s1, s2;
  logic [WIDTH-1:0] mag1, mag2;

  assign op_div      = md_op[3];
  assign op_divu     = md_op[2];
  assign op_mult     = md_op[1];
  assign is_div_op   = op_div | op_divu;
  assign signed_op   = op_div | op_mult;
  assign start       = (md_op != 4'b0000) && !annul;
  assign div_by_zero = is_div_op && (md_src2 == '0);

  // Operand signs are only honoured for signed ops; unsigned ops latch raw.
  // The most negative value negates to itself, which is the correct
  // unsigned magnitude.
  assign s1   = signed_op & md_src1[WIDTH-1];
  assign s2   = signed_op & md_src2[WIDTH-1];
  assign mag1 = s1 ? neg_w(md_src1) : md_src1;
  assign mag2 = s2 ? neg_w(md_src2) : md_src2;

  // ---------------------------------------------------------------------------
  // Datapath registers
  //   src_q : multiplicand (mult) or divisor (div)
  //   acc_q : mult -> {partial product, remaining multiplier bits}
  //           div  -> {partial remainder, dividend bits / quotient bits}
  // ---------------------------------------------------------------------------
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   src_q, src_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               is_div_q, is_div_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic last_step;
  assign last_step = (cnt_q == CntW'(WIDTH - 1));

  // Multiply step: add the multiplicand to the upper half when the current
  // multiplier LSB is set, then shift the whole accumulator right by one.
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, src_q} : '0);
  assign mul_next = {add_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step: shift in the next dividend bit and subtract the
  // divisor if it fits. part_rem is one bit wider than the operands so the
  // shifted remainder can never overflow.
  logic [WIDTH:0]     part_rem;
  logic [WIDTH-1:0]   diff;
  logic               q_bit;
  logic [WIDTH-1:0]   new_rem;
  logic [2*WIDTH-1:0] div_next;

  assign part_rem = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign q_bit    = (part_rem >= {1'b0, src_q});
  // When q_bit is set the true difference is below the divisor, so the
  // truncated subtraction is exact.
  assign diff     = part_rem[WIDTH-1:0] - src_q;
  assign new_rem  = q_bit ? diff : part_rem[WIDTH-1:0];
  assign div_next = {new_rem, acc_q[WIDTH-2:0], q_bit};

  // Sign fix-up applied to the final step's value.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign prod_fix = q_neg_q ? neg_2w(mul_next) : mul_next;
  assign quo_fix  = q_neg_q ? neg_w(div_next[WIDTH-1:0]) : div_next[WIDTH-1:0];
  assign rem_fix  = r_neg_q ? neg_w(div_next[2*WIDTH-1:WIDTH]) : div_next[2*WIDTH-1:WIDTH];
  assign res_hi   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo   = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = div_by_zero ? StDone : StCalc;
        end
      end
      StCalc: begin
        if (annul) begin
          state_d = StIdle;
        end else if (last_step) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    md_done         = 1'b0;
    stallreq_for_md = 1'b0;
    case (state_q)
      StIdle: stallreq_for_md = !rst && start;
      StCalc: stallreq_for_md = !rst && !annul;
      StDone: md_done         = !annul;
      default: ;
    endcase
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d    = cnt_q;
    src_d    = src_q;
    acc_d    = acc_q;
    is_div_d = is_div_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d    = '0;
          is_div_d = is_div_op;
          q_neg_d  = s1 ^ s2;
          r_neg_d  = op_div & s1;
          if (div_by_zero) begin
            // Results go straight to the output registers; no iteration.
            hi_d = md_src1;
            lo_d = '1;
          end else if (is_div_op) begin
            src_d = mag2;
            acc_d = {{WIDTH{1'b0}}, mag1};
          end else begin
            src_d = mag1;
            acc_d = {{WIDTH{1'b0}}, mag2};
          end
        end
      end
      StCalc: begin
        if (!annul) begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + CntW'(1);
          if (last_step) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      src_q    <= '0;
      acc_q    <= '0;
      is_div_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      src_q    <= src_d;
      acc_q    <= acc_d;
      is_div_q <= is_div_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide sequencer for the EX stage. It replaces the single-cycle combinational `*`, `/` and `%` in the HI/LO path with an iterative engine that computes one bit per cycle. While an operation is in flight it holds the pipeline through the stall bus, then hands the HI/LO pair to EX for the existing `hilo_bus` write. It serves MULT, MULTU, DIV and DIVU. MTHI, MTLO, MFHI and MFLO stay combinational in EX.

## Interface
- `WIDTH`, default 32, operand width; HI/LO results are each WIDTH bits.

- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `md_op`  in  4  `{inst_div, inst_divu, inst_mult, inst_multu}` from EX decode; one-hot or zero.
- `md_src1`  in  WIDTH  rs value (dividend / multiplicand).
- `md_src2`  in  WIDTH  rt value (divisor / multiplier).
- `annul`  in  1  cancel the current or pending operation (flush).
- `stallreq_for_md`  out  1  request to the stall controller to freeze the IF through EX stages.
- `md_done`  out  1  high for one cycle; `hi_o` and `lo_o` are valid and EX asserts `hi_we`/`lo_we`.
- `hi_o`  out  WIDTH  remainder (div) or product[63:32] (mult).
- `lo_o`  out  WIDTH  quotient (div) or product[31:0] (mult).

## Operation
- States are IDLE, CALC and DONE. The state register, counter and datapath registers use async reset.
- **IDLE:**
  - `start` = `md_op != 0 && !annul`.
  - On `start` the block latches magnitudes, signs, op kind and clears the 6-bit counter.
    - DIV and MULT take the two's-complement magnitude of each operand.
    - `0x8000_0000` maps to `0x8000_0000` as an unsigned value.
    - DIVU and MULTU latch the operands raw.
  - Sign latches: `q_neg = s1 ^ s2` (signed ops only); `r_neg = s1` (DIV only).
  - Next state is CALC.
  - Exception: DIV/DIVU with `md_src2 == 0` goes straight to DONE with `hi = md_src1`, `lo = 0xFFFF_FFFF`.
- **CALC, multiply:** unsigned shift-add, one multiplier bit per cycle, LSB first, into a 2·WIDTH accumulator.
- **CALC, divide:** restoring division, one quotient bit per cycle, MSB first.
  - Partial remainder is WIDTH+1 bits wide, so no overflow occurs.
- **CALC, counter:** counts 0..WIDTH-1. On the step where counter = WIDTH-1 the block applies the sign fix-up, loads the result registers and moves to DONE.
  - Multiply: negate the 64-bit product if `q_neg`.
  - Divide: negate the quotient if `q_neg`; negate the remainder if `r_neg`.
- **DONE:** `md_done` = 1 and next state is IDLE.
- `hi_o`/`lo_o` are registers loaded only on entry to DONE. They hold their value until the next DONE.
- `md_op`, `md_src1` and `md_src2` are ignored outside IDLE. The operands are taken from the latched copies only.
- `annul`:
  - In CALC or DONE: next state is IDLE, no `md_done` pulse, `hi_o`/`lo_o` unchanged.
  - In IDLE: suppresses `start`.
- `stallreq_for_md` = `!rst && !annul && ((IDLE && start) || CALC)`. This is combinational, so the instruction is held in EX from its first cycle.
- In DONE the stall is low. The EX bus register advances at the end of the DONE cycle, so a back-to-back md instruction is seen in the following IDLE cycle.

## Timing
- Let T be the first cycle an md instruction is in EX while the block is IDLE.
- **Normal op:**
  - CALC occupies T+1..T+WIDTH.
  - DONE is at T+WIDTH+1 (T+33 when WIDTH = 32).
  - Stall is high T..T+32 and low at T+33.
- **Divide by zero:** stall is high at T only; DONE is at T+1.
- **Back-to-back ops:** the second op's T equals the first op's DONE cycle + 1.
- **Reset:** state IDLE, counter 0, `hi_o` = `lo_o` = 0, `md_done` = 0, `stallreq_for_md` = 0.
  - Reset takes effect immediately, including in the middle of CALC.
  - The first op after reset release starts in the cycle it is seen.
- `annul` takes effect on the next clock edge for state. It is combinational on `stallreq_for_md`.

## Test plan
- DIVU 100 / 7 at T -> stall high for T..T+32; `md_done` at T+33 with `lo` = 14, `hi` = 2.
- DIV -7 / 2 (0xFFFF_FFF9, 2) -> `lo` = 0xFFFF_FFFD, `hi` = 0xFFFF_FFFF. Also DIV 0x8000_0000 / 0xFFFF_FFFF -> `lo` = 0x8000_0000, `hi` = 0.
- Multiply 0xFFFF_FFFF × 0xFFFF_FFFF:
  - MULT -> `hi` = 0, `lo` = 1.
  - MULTU -> `hi` = 0xFFFF_FFFE, `lo` = 1.
  - Both report `md_done` at T+33.
- DIVU 5 / 0 -> stall only at T; `md_done` at T+1 with `hi` = 5, `lo` = 0xFFFF_FFFF.
- Interrupted operations:
  - DIV started and `annul` pulsed at T+10 -> stall low in T+10, IDLE at T+11, no `md_done`, `hi_o`/`lo_o` keep their previous values.
  - Async `rst` at T+15 -> all outputs 0 immediately.
- MULTU 3×4 immediately followed by DIVU 9/2 -> `done1` at T+33 (`lo` = 12); second op T' = T+34; `done2` at T'+33 (`lo` = 4, `hi` = 1).
